pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 20 ++
 rtl/pipeline_ctrl.sv | 59 +++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard-unit signal bundle between the pipeline datapath (master) and controller (slave).
interface pipeline_ctrl_if #(parameter int DATA_WIDTH = 32);
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr;
    logic [1:0] ForwardAE, ForwardBE;
    logic [DATA_WIDTH-1:0] StallCount;
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr,
        input  ForwardAE, ForwardBE, StallCount
    );
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr,
        output ForwardAE, ForwardBE, StallCount
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage hazard unit -- forwarding, load-use stall, branch flush and memory-wait FSM with timeout.
module pipeline_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic clk,
    input logic rst,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;
    state_e state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic lw_stall, mem_stall, stall_f;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        lw_stall  = bus.ResultSrcE0 && bus.RdE != 5'd0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
        // In MEM_WAIT the ready cycle itself releases the pipeline.
        mem_stall = state_q == ERROR || (!bus.MemReadyM && (state_q == MEM_WAIT || bus.MemReqM));
        stall_f   = mem_stall || lw_stall;
        state_d   = state_q;
        wait_d    = wait_q;
        case (state_q)
            RUN: if (bus.MemReqM && !bus.MemReadyM) begin
                state_d = MEM_WAIT;
                wait_d  = '0;
            end
            MEM_WAIT: if (bus.MemReadyM) state_d = RUN;
                else if (wait_q == 8'(TIMEOUT)) state_d = ERROR;
                else wait_d = wait_q + 8'd1;
            default: ;
        endcase
        cnt_d = (stall_f && !(&cnt_q)) ? cnt_q + DATA_WIDTH'(1) : cnt_q;
    end
    assign bus.ForwardAE  = (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == bus.Rs1E) ? 2'b10 :
                            (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.Rs1E) ? 2'b01 : 2'b00;
    assign bus.ForwardBE  = (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == bus.Rs2E) ? 2'b10 :
                            (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.Rs2E) ? 2'b01 : 2'b00;
    assign bus.StallF     = stall_f;
    assign bus.StallD     = stall_f;
    assign bus.StallE     = mem_stall;
    assign bus.StallM     = mem_stall;
    assign bus.StallW     = mem_stall;
    // A branch resolved while memory stalls is deferred; Execute is held so it reasserts on release.
    assign bus.FlushD     = !mem_stall && bus.PCSrcE;
    assign bus.FlushE     = !mem_stall && (lw_stall || bus.PCSrcE);
    assign bus.MemErr     = state_q == ERROR;
    assign bus.StallCount = cnt_q;
endmodule
